// File: rtl/psola_frame_sequencer.sv
// Frame-level controller for the autotune chain: ping-pong input capture,
// pitch-detect kick-off, accumulation-buffer clear, psola start and playback
// handoff, plus overrun counting, unvoiced skip and synthesis watchdog.
// Ports:
//   clk_in, rst_in                   clock, async active-high reset
//   sample_valid_in, sample_in       audio sample stream
//   in_wr_*_out                      registered input-buffer write port
//   detect_start_out, proc_bank_out  pitch detector start / bank in process
//   tau_valid_in, tau_in             detected period
//   clr_en_out, clr_addr_out         accumulation-buffer clear port
//   psola_tau_valid_out, psola_tau_out  psola start pulse and period
//   window_len_valid_in, window_len_in  psola done and frame length
//   playback_busy_in                 playback still reading accumulation buffer
//   frame_ready_out, frame_len_out   finished frame report
//   frame_skip_out                   dropped (unvoiced / timed-out) frame
//   busy_out, overrun_count_out      status
module psola_frame_sequencer #(
    parameter int WINDOW_SIZE    = 2048,
    parameter int MAX_EXTENDED   = 2200,
    parameter int MIN_TAU        = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            sample_valid_in,
    input  logic [15:0]                     sample_in,
    output logic                            in_wr_en_out,
    output logic                            in_wr_bank_out,
    output logic [$clog2(WINDOW_SIZE)-1:0]  in_wr_addr_out,
    output logic [15:0]                     in_wr_data_out,
    output logic                            detect_start_out,
    output logic                            proc_bank_out,
    input  logic                            tau_valid_in,
    input  logic [10:0]                     tau_in,
    output logic                            clr_en_out,
    output logic [$clog2(MAX_EXTENDED)-1:0] clr_addr_out,
    output logic                            psola_tau_valid_out,
    output logic [10:0]                     psola_tau_out,
    input  logic                            window_len_valid_in,
    input  logic [11:0]                     window_len_in,
    input  logic                            playback_busy_in,
    output logic                            frame_ready_out,
    output logic [11:0]                     frame_len_out,
    output logic                            frame_skip_out,
    output logic                            busy_out,
    output logic [7:0]                      overrun_count_out
);

    localparam int AW = $clog2(WINDOW_SIZE);
    localparam int CW = $clog2(MAX_EXTENDED);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    localparam logic [AW-1:0] LAST_FILL = AW'(WINDOW_SIZE - 1);
    localparam logic [CW-1:0] LAST_CLR  = CW'(MAX_EXTENDED - 1);
    localparam logic [WW-1:0] LAST_WD   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0]   MIN_T     = 11'(MIN_TAU);
    localparam logic [11:0]   HALF_WIN  = 12'(WINDOW_SIZE / 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        CLEAR  = 2'd2,
        SYNTH  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   fill_cnt_q, fill_cnt_d;
    logic            fill_bank_q, fill_bank_d;
    logic            wr_en_q, wr_en_d;
    logic            wr_bank_q, wr_bank_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic            detect_q, detect_d;
    logic            proc_bank_q, proc_bank_d;
    logic [10:0]     tau_q, tau_d;
    logic            tau_vld_q, tau_vld_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [11:0]     len_q, len_d;
    logic            ready_q, ready_d;
    logic            skip_q, skip_d;
    logic [7:0]      ovr_q, ovr_d;
    logic            frame_done;
    logic            tau_bad;

    assign frame_done = sample_valid_in && (fill_cnt_q == LAST_FILL);
    assign tau_bad    = (tau_in < MIN_T) || ({1'b0, tau_in} >= HALF_WIN);

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        fill_bank_d = fill_bank_q;
        wr_en_d     = sample_valid_in;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        detect_d    = 1'b0;
        proc_bank_d = proc_bank_q;
        tau_d       = tau_q;
        tau_vld_d   = 1'b0;
        clr_cnt_d   = clr_cnt_q;
        wd_d        = wd_q;
        len_d       = len_q;
        ready_d     = 1'b0;
        skip_d      = 1'b0;
        ovr_d       = ovr_q;

        // Fill path is free-running; power-of-two window wraps naturally.
        if (sample_valid_in) begin
            wr_bank_d  = fill_bank_q;
            wr_addr_d  = fill_cnt_q;
            wr_data_d  = sample_in;
            fill_cnt_d = fill_cnt_q + 1'b1;
        end

        // A frame finishing while busy is dropped and its bank reused,
        // so the bank under processing is never overwritten.
        if (frame_done) begin
            if (state_q == IDLE) begin
                proc_bank_d = fill_bank_q;
                fill_bank_d = ~fill_bank_q;
                detect_d    = 1'b1;
                state_d     = DETECT;
            end else if (ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end

        unique case (state_q)
            IDLE: ;
            DETECT: begin
                if (tau_valid_in) begin
                    if (tau_bad) begin
                        skip_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tau_d     = tau_in;
                        clr_cnt_d = '0;
                        state_d   = CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (!playback_busy_in) begin
                    if (clr_cnt_q == LAST_CLR) begin
                        clr_cnt_d = '0;
                        tau_vld_d = 1'b1;
                        wd_d      = '0;
                        state_d   = SYNTH;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            SYNTH: begin
                wd_d = wd_q + 1'b1;
                if (window_len_valid_in) begin
                    len_d   = window_len_in;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (wd_q == LAST_WD) begin
                    skip_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            fill_bank_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            detect_q    <= 1'b0;
            proc_bank_q <= 1'b0;
            tau_q       <= '0;
            tau_vld_q   <= 1'b0;
            clr_cnt_q   <= '0;
            wd_q        <= '0;
            len_q       <= '0;
            ready_q     <= 1'b0;
            skip_q      <= 1'b0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_bank_q <= fill_bank_d;
            wr_en_q     <= wr_en_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            detect_q    <= detect_d;
            proc_bank_q <= proc_bank_d;
            tau_q       <= tau_d;
            tau_vld_q   <= tau_vld_d;
            clr_cnt_q   <= clr_cnt_d;
            wd_q        <= wd_d;
            len_q       <= len_d;
            ready_q     <= ready_d;
            skip_q      <= skip_d;
            ovr_q       <= ovr_d;
        end
    end

    assign in_wr_en_out        = wr_en_q;
    assign in_wr_bank_out      = wr_bank_q;
    assign in_wr_addr_out      = wr_addr_q;
    assign in_wr_data_out      = wr_data_q;
    assign detect_start_out    = detect_q;
    assign proc_bank_out       = proc_bank_q;
    // Clear strobe follows playback combinationally so a stall costs no slot.
    assign clr_en_out          = (state_q == CLEAR) && !playback_busy_in;
    assign clr_addr_out        = clr_cnt_q;
    assign psola_tau_valid_out = tau_vld_q;
    assign psola_tau_out       = tau_q;
    assign frame_ready_out     = ready_q;
    assign frame_len_out       = len_q;
    assign frame_skip_out      = skip_q;
    assign busy_out            = (state_q != IDLE);
    assign overrun_count_out   = ovr_q;

endmodule

// File: tb/tb_psola_frame_sequencer.sv
// Directed bench for psola_frame_sequencer using scaled-down parameters
// (64-sample window, 100-word clear, MIN_TAU 8, 500-cycle watchdog).
module tb_psola_frame_sequencer;

    localparam int WS = 64;
    localparam int ME = 100;
    localparam int MT = 8;
    localparam int TO = 500;
    localparam int AW = $clog2(WS);
    localparam int CW = $clog2(ME);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_valid_in = 1'b0;
    logic [15:0]   sample_in = '0;
    logic          in_wr_en_out;
    logic          in_wr_bank_out;
    logic [AW-1:0] in_wr_addr_out;
    logic [15:0]   in_wr_data_out;
    logic          detect_start_out;
    logic          proc_bank_out;
    logic          tau_valid_in = 1'b0;
    logic [10:0]   tau_in = '0;
    logic          clr_en_out;
    logic [CW-1:0] clr_addr_out;
    logic          psola_tau_valid_out;
    logic [10:0]   psola_tau_out;
    logic          window_len_valid_in = 1'b0;
    logic [11:0]   window_len_in = '0;
    logic          playback_busy_in = 1'b0;
    logic          frame_ready_out;
    logic [11:0]   frame_len_out;
    logic          frame_skip_out;
    logic          busy_out;
    logic [7:0]    overrun_count_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int seq     = 0;

    psola_frame_sequencer #(
        .WINDOW_SIZE(WS), .MAX_EXTENDED(ME),
        .MIN_TAU(MT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .sample_valid_in(sample_valid_in), .sample_in(sample_in),
        .in_wr_en_out(in_wr_en_out), .in_wr_bank_out(in_wr_bank_out),
        .in_wr_addr_out(in_wr_addr_out), .in_wr_data_out(in_wr_data_out),
        .detect_start_out(detect_start_out), .proc_bank_out(proc_bank_out),
        .tau_valid_in(tau_valid_in), .tau_in(tau_in),
        .clr_en_out(clr_en_out), .clr_addr_out(clr_addr_out),
        .psola_tau_valid_out(psola_tau_valid_out),
        .psola_tau_out(psola_tau_out),
        .window_len_valid_in(window_len_valid_in),
        .window_len_in(window_len_in),
        .playback_busy_in(playback_busy_in),
        .frame_ready_out(frame_ready_out), .frame_len_out(frame_len_out),
        .frame_skip_out(frame_skip_out), .busy_out(busy_out),
        .overrun_count_out(overrun_count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid_in = 1'b1;
            sample_in = 16'(seq);
            seq++;
            tick();
        end
        sample_valid_in = 1'b0;
    endtask

    task automatic pulse_tau(input int t);
        tau_valid_in = 1'b1;
        tau_in = 11'(t);
        tick();
        tau_valid_in = 1'b0;
    endtask

    // Walks the clear sweep until the psola start pulse or a bound expires.
    task automatic run_clear(output int nclr, output int aerr, output int k);
        nclr = 0;
        aerr = 0;
        k = 0;
        while (!psola_tau_valid_out && k < 4 * ME) begin
            if (clr_en_out) begin
                if (int'(clr_addr_out) != nclr) aerr++;
                nclr++;
            end
            tick();
            k++;
        end
    endtask

    initial begin
        int werr, early, nclr, aerr, k, stall, pcyc, t0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_wr_en", int'(in_wr_en_out), 0);
        chk("rst_ovr", int'(overrun_count_out), 0);
        chk("rst_ptau", int'(psola_tau_out), 0);
        rst = 1'b0;
        tick();

        // First frame into bank 0
        werr = 0;
        early = 0;
        for (int i = 0; i < WS; i++) begin
            sample_valid_in = 1'b1;
            sample_in = 16'hA000 + 16'(i);
            tick();
            if (!(in_wr_en_out && int'(in_wr_addr_out) == i &&
                  !in_wr_bank_out && in_wr_data_out == 16'hA000 + 16'(i)))
                werr++;
            if (i < WS - 1 && detect_start_out) early++;
        end
        sample_valid_in = 1'b0;
        chk("f0_writes", werr, 0);
        chk("f0_no_early_detect", early, 0);
        chk("f0_detect", int'(detect_start_out), 1);
        chk("f0_proc_bank", int'(proc_bank_out), 0);
        chk("f0_busy", int'(busy_out), 1);
        tick();
        chk("f0_detect_1cyc", int'(detect_start_out), 0);
        feed(1);
        chk("f1_bank", int'(in_wr_bank_out), 1);
        chk("f1_addr", int'(in_wr_addr_out), 0);

        // Voiced frame: clear sweep, psola start, done
        pulse_tau(20);
        run_clear(nclr, aerr, k);
        chk("clr_count", nclr, ME);
        chk("clr_addr_seq", aerr, 0);
        chk("tau_to_start", k + 1, ME + 1);
        chk("psola_vld", int'(psola_tau_valid_out), 1);
        chk("psola_tau", int'(psola_tau_out), 20);
        tick();
        chk("psola_vld_1cyc", int'(psola_tau_valid_out), 0);
        chk("synth_busy", int'(busy_out), 1);
        window_len_valid_in = 1'b1;
        window_len_in = 12'd1800;
        tick();
        window_len_valid_in = 1'b0;
        chk("ready", int'(frame_ready_out), 1);
        chk("ready_len", int'(frame_len_out), 1800);
        chk("ready_idle", int'(busy_out), 0);
        tick();
        chk("ready_1cyc", int'(frame_ready_out), 0);
        chk("tau_hold_idle", int'(psola_tau_out), 20);

        // Unvoiced frame (tau below MIN_TAU)
        feed(WS - 1);
        chk("f1_detect", int'(detect_start_out), 1);
        chk("f1_proc_bank", int'(proc_bank_out), 1);
        pulse_tau(5);
        chk("low_skip", int'(frame_skip_out), 1);
        chk("low_idle", int'(busy_out), 0);
        chk("low_no_clr", int'(clr_en_out), 0);
        tick();
        chk("low_skip_1cyc", int'(frame_skip_out), 0);
        chk("low_no_start", int'(psola_tau_valid_out), 0);
        chk("low_tau_kept", int'(psola_tau_out), 20);
        pulse_tau(20);
        chk("idle_tau_ignored", int'(busy_out), 0);

        // tau at WINDOW/2 also skips
        feed(WS);
        chk("f2_proc_bank", int'(proc_bank_out), 0);
        pulse_tau(WS / 2);
        chk("half_skip", int'(frame_skip_out), 1);
        chk("half_idle", int'(busy_out), 0);

        // tau == MIN_TAU accepted, with playback stall on CLEAR entry
        feed(WS);
        chk("f3_proc_bank", int'(proc_bank_out), 1);
        playback_busy_in = 1'b1;
        pulse_tau(MT);
        chk("min_accept", int'(busy_out), 1);
        chk("min_no_skip", int'(frame_skip_out), 0);
        stall = 0;
        for (int j = 0; j < 30; j++) begin
            if (clr_en_out) stall++;
            tick();
        end
        chk("stall_no_clr", stall, 0);
        playback_busy_in = 1'b0;
        #1;
        run_clear(nclr, aerr, k);
        pcyc = cyc;
        chk("stall_clr_count", nclr, ME);
        chk("stall_addr_seq", aerr, 0);
        chk("stall_sweep_len", k, ME);
        chk("stall_tau", int'(psola_tau_out), MT);

        // Overrun during SYNTH keeps the fill bank
        feed(WS);
        chk("ovr_one", int'(overrun_count_out), 1);
        chk("ovr_bank", int'(in_wr_bank_out), 0);
        chk("ovr_proc_bank", int'(proc_bank_out), 1);
        feed(1);
        chk("ovr_next_bank", int'(in_wr_bank_out), 0);
        chk("ovr_next_addr", int'(in_wr_addr_out), 0);

        // Watchdog timeout
        while (!frame_skip_out && cyc - pcyc < 2 * TO) tick();
        chk("wd_cycles", cyc - pcyc, TO);
        chk("wd_skip", int'(frame_skip_out), 1);
        chk("wd_idle", int'(busy_out), 0);
        window_len_valid_in = 1'b1;
        tick();
        window_len_valid_in = 1'b0;
        chk("idle_len_ignored", int'(frame_ready_out), 0);

        // Overrun saturation while parked in DETECT
        feed(WS - 1);
        chk("f4_detect", int'(detect_start_out), 1);
        chk("f4_proc_bank", int'(proc_bank_out), 0);
        window_len_valid_in = 1'b1;
        tick();
        window_len_valid_in = 1'b0;
        chk("det_len_ignored", int'(frame_ready_out), 0);
        chk("det_still_busy", int'(busy_out), 1);
        for (int f = 0; f < 300; f++) begin
            feed(WS);
            if (f == 252) chk("ovr_254", int'(overrun_count_out), 254);
        end
        chk("ovr_sat", int'(overrun_count_out), 255);
        chk("ovr_sat_bank", int'(in_wr_bank_out), 1);

        // Asynchronous reset in the middle of CLEAR
        pulse_tau(20);
        for (int j = 0; j < 5; j++) tick();
        chk("mid_clr_en", int'(clr_en_out), 1);
        chk("mid_clr_addr", int'(clr_addr_out), 5);
        t0 = cyc;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_same_cycle", cyc - t0, 0);
        chk("arst_clr_en", int'(clr_en_out), 0);
        chk("arst_clr_addr", int'(clr_addr_out), 0);
        chk("arst_busy", int'(busy_out), 0);
        chk("arst_ovr", int'(overrun_count_out), 0);
        chk("arst_ptau", int'(psola_tau_out), 0);
        chk("arst_wr_bank", int'(in_wr_bank_out), 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rel_no_pulse", int'({detect_start_out, frame_skip_out,
                                  frame_ready_out, psola_tau_valid_out}), 0);
        feed(1);
        chk("rel_bank", int'(in_wr_bank_out), 0);
        chk("rel_addr", int'(in_wr_addr_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psola_frame_sequencer.md
Name: psola_frame_sequencer

Overview:
- Frame-level controller for the autotune chain: captures the audio stream into a ping-pong input buffer and starts pitch detection on each full frame.
- Clears the PSOLA accumulation buffer, hands the detected period to the psola datapath and reports the finished output frame to the playback side.
- Owns bank selection, overrun/skip/timeout handling and the psola start pulse. Sits between the audio sample source, the pitch detector, psola and playback.

Parameters:
WINDOW_SIZE, 2048, samples per analysis frame (power of two)
MAX_EXTENDED, 2200, accumulation-buffer depth to clear before each synthesis
MIN_TAU, 32, smallest period treated as voiced; smaller tau skips synthesis
TIMEOUT_CYCLES, 65536, SYNTH watchdog limit in clk_in cycles

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
sample_valid_in  in  1  one input audio sample this cycle
sample_in  in  16  input sample
in_wr_en_out  out  1  input-buffer write strobe (registered)
in_wr_bank_out  out  1  input-buffer bank being written
in_wr_addr_out  out  $clog2(WINDOW_SIZE)  input-buffer write address
in_wr_data_out  out  16  registered copy of sample_in
detect_start_out  out  1  one-cycle pulse: start pitch detection
proc_bank_out  out  1  bank under detection/synthesis, stable until IDLE
tau_valid_in  in  1  pitch detector result strobe
tau_in  in  11  detected period in samples
clr_en_out  out  1  write-zero strobe to accumulation buffer
clr_addr_out  out  $clog2(MAX_EXTENDED)  clear address
psola_tau_valid_out  out  1  one-cycle psola start pulse
psola_tau_out  out  11  period to psola, held stable through SYNTH
window_len_valid_in  in  1  psola done strobe
window_len_in  in  12  synthesized frame length
playback_busy_in  in  1  playback still reading accumulation buffer
frame_ready_out  out  1  one-cycle pulse: output frame available
frame_len_out  out  12  length of the last ready frame
frame_skip_out  out  1  one-cycle pulse: unvoiced or timed-out frame dropped
busy_out  out  1  state != IDLE
overrun_count_out  out  8  saturating dropped-frame counter

Behaviour:
- Reset (async): all outputs 0, state IDLE, fill counter 0, fill bank 0, tau latch 0.
- Fill path runs independently of the FSM:
  - On sample_valid_in, the next cycle has in_wr_en_out=1, addr=fill_cnt, bank=fill_bank, data=sample_in; fill_cnt increments.
  - frame_done fires when the accepted sample has fill_cnt==WINDOW_SIZE-1; fill_cnt wraps to 0.
- frame_done with state==IDLE (sampled register value that cycle):
  - proc_bank_out<=fill_bank; fill_bank toggles.
  - detect_start_out pulses the next cycle; state->DETECT.
- frame_done with state!=IDLE:
  - Frame dropped; overrun_count_out++ saturating at 255.
  - fill_bank does not toggle, so the bank under processing is never overwritten.
- FSM states IDLE, DETECT, CLEAR, SYNTH:
  - DETECT: wait tau_valid_in.
    - tau_in<MIN_TAU or tau_in>=WINDOW_SIZE/2: frame_skip_out pulse, ->IDLE.
    - Otherwise latch psola_tau_out=tau_in, ->CLEAR.
  - CLEAR:
    - Stalls with clr_en_out=0 while playback_busy_in=1.
    - Otherwise clr_en_out=1 with clr_addr_out 0..MAX_EXTENDED-1, one address per cycle.
    - After the last address, psola_tau_valid_out pulses one cycle; ->SYNTH. Watchdog cleared.
  - SYNTH: watchdog increments each cycle.
    - window_len_valid_in: frame_len_out<=window_len_in; frame_ready_out pulses the next cycle; ->IDLE.
    - Watchdog reaches TIMEOUT_CYCLES-1 without done: frame_skip_out pulse, ->IDLE.
- tau_valid_in or window_len_valid_in in any state other than its own waiting state: ignored.
- psola_tau_out holds its value in IDLE until the next latch. psola samples tau throughout synthesis.
- Total fixed overhead from tau_valid_in to psola_tau_valid_out is MAX_EXTENDED+1 cycles when playback is idle.
- Reset asserted mid-frame: all state, counters and banks return to reset values immediately. No pulse is emitted on release.

Test Plan:
- Reset, then WINDOW_SIZE samples with valid every cycle -> detect_start_out high exactly one cycle after the 2048th write; proc_bank_out=0; next fill writes bank 1 starting at addr 0.
- DETECT, tau_in=200 -> 2200 clr_en_out cycles with addr 0..2199, then one psola_tau_valid_out with psola_tau_out=200; window_len_valid_in with 1800 -> frame_ready_out pulse, frame_len_out=1800, busy_out=0.
- tau_in=10 (<MIN_TAU) -> frame_skip_out pulse, no clr_en_out, no psola_tau_valid_out, state IDLE.
- Second frame completes during SYNTH -> overrun_count_out=1, fill_bank unchanged (writes stay on bank 1); 300 overruns -> count saturates at 255.
- playback_busy_in held high 100 cycles on CLEAR entry -> no clr_en_out for 100 cycles, then the full sweep completes.
- SYNTH with no window_len_valid_in for 65536 cycles -> frame_skip_out pulse, IDLE; assert rst_in mid-CLEAR -> all outputs 0 asynchronously.
